// File: rtl/dpad_matrix_editor.sv
// LED-matrix pixel editor: d-pad moves a blinking cursor over a ROWS x COLS
// framebuffer, A/B set/clear pixels, clr_n sweeps the buffer clear.
module dpad_matrix_editor #(
  parameter int unsigned ROWS      = 8,
  parameter int unsigned COLS      = 8,
  parameter int unsigned SCAN_SH   = 13,
  parameter int unsigned BLINK_SH  = 21,
  parameter int unsigned DEB_CYC   = 65536,
  parameter int unsigned RPT_DLY   = 512,
  parameter int unsigned RPT_RATE  = 64,
  parameter int unsigned WRAP      = 1,
  parameter int unsigned INIT_DIAG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               btn,
  input  logic                     Abtn,
  input  logic                     Bbtn,
  input  logic                     clr_n,
  output logic [COLS-1:0]          col,
  output logic [ROWS-1:0]          row,
  output logic [$clog2(COLS)-1:0]  cur_x,
  output logic [$clog2(ROWS)-1:0]  cur_y,
  output logic                     busy
);

  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned CW    = $clog2(COLS);
  localparam int unsigned NIN   = 7;
  localparam int unsigned DW    = $clog2(DEB_CYC + 1);
  localparam int unsigned RMAX  = (RPT_DLY > RPT_RATE) ? RPT_DLY : RPT_RATE;
  localparam int unsigned RCW   = $clog2(RMAX + 1);
  localparam int unsigned CNT_W = ((SCAN_SH + RW) > (BLINK_SH + 1)) ? (SCAN_SH + RW) : (BLINK_SH + 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e           state_q, state_d;
  logic [NIN-1:0]   sync1_q, sync2_q;
  logic [NIN-1:0]   deb_q, deb_d;
  logic [DW-1:0]    deb_cnt_q [NIN];
  logic [DW-1:0]    deb_cnt_d [NIN];
  logic             clr_prev_q, clr_prev_d;
  logic [3:0]       dir_q, dir_d;
  logic [RCW-1:0]   rpt_cnt_q, rpt_cnt_d;
  logic             rpt_first_q, rpt_first_d;
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [CW-1:0]    cur_x_q, cur_x_d;
  logic [RW-1:0]    cur_y_q, cur_y_d;
  logic [RW-1:0]    clr_row_q, clr_row_d;
  logic [COLS-1:0]  fb_q [ROWS];
  logic [COLS-1:0]  fb_d [ROWS];
  logic [COLS-1:0]  col_q, col_d;
  logic [ROWS-1:0]  row_q, row_d;
  logic             busy_q, busy_d;

  logic [NIN-1:0]   raw_c;
  logic [3:0]       press_c, dir_c;
  logic             tick_c, move_c, clr_fall_c;
  logic [RW-1:0]    s_c;
  logic             blink_c;

  assign raw_c = {clr_n, Bbtn, Abtn, btn};

  // Per-input stability counter: level flips after DEB_CYC differing samples in a row
  always_comb begin
    deb_d = deb_q;
    for (int unsigned i = 0; i < NIN; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DW'(DEB_CYC - 1)) deb_d[i] = sync2_q[i];
        else deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
      end
    end
  end

  assign press_c = ~deb_q[3:0];
  assign dir_c   = $onehot(press_c) ? press_c : 4'b0000;
  assign tick_c  = &scan_cnt_q[SCAN_SH-1:0];

  // Press edge moves once; a held direction repeats after RPT_DLY ticks, then every RPT_RATE
  always_comb begin
    dir_d       = dir_c;
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    move_c      = 1'b0;
    if (dir_c == 4'b0000) begin
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b1;
    end else if (dir_c != dir_q) begin
      move_c      = 1'b1;
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b1;
    end else if (tick_c) begin
      if ((32'(rpt_cnt_q) + 32'd1) == (rpt_first_q ? RPT_DLY : RPT_RATE)) begin
        move_c      = 1'b1;
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RCW'(1);
      end
    end
  end

  // Cursor update; edges wrap or clamp at COLS-1/ROWS-1
  always_comb begin
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    if (move_c && (state_q == S_IDLE)) begin
      if (dir_c[3]) begin
        if (cur_x_q == CW'(COLS - 1)) cur_x_d = (WRAP != 0) ? '0 : cur_x_q;
        else cur_x_d = cur_x_q + CW'(1);
      end else if (dir_c[0]) begin
        if (cur_x_q == '0) cur_x_d = (WRAP != 0) ? CW'(COLS - 1) : '0;
        else cur_x_d = cur_x_q - CW'(1);
      end else if (dir_c[1]) begin
        if (cur_y_q == RW'(ROWS - 1)) cur_y_d = (WRAP != 0) ? '0 : cur_y_q;
        else cur_y_d = cur_y_q + RW'(1);
      end else if (dir_c[2]) begin
        if (cur_y_q == '0) cur_y_d = (WRAP != 0) ? RW'(ROWS - 1) : '0;
        else cur_y_d = cur_y_q - RW'(1);
      end
    end
  end

  assign clr_fall_c = clr_prev_q & ~deb_q[6];

  // IDLE edits at the post-move cursor (B beats A); CLEAR zeros one row per clock
  always_comb begin
    state_d    = state_q;
    clr_row_d  = clr_row_q;
    clr_prev_d = deb_q[6];
    fb_d       = fb_q;
    case (state_q)
      S_IDLE: begin
        if (!deb_q[5]) fb_d[cur_y_d][cur_x_d] = 1'b0;
        else if (!deb_q[4]) fb_d[cur_y_d][cur_x_d] = 1'b1;
        if (clr_fall_c) begin
          state_d   = S_CLEAR;
          clr_row_d = '0;
        end
      end
      S_CLEAR: begin
        fb_d[clr_row_q] = '0;
        if (clr_row_q == RW'(ROWS - 1)) state_d = S_IDLE;
        else clr_row_d = clr_row_q + RW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_CLEAR);
  end

  assign s_c     = RW'(32'(scan_cnt_q[SCAN_SH +: RW]) % ROWS);
  assign blink_c = scan_cnt_q[BLINK_SH];

  // Row scan and column data; cursor pixel ORed in during the lit blink phase
  always_comb begin
    scan_cnt_d = scan_cnt_q + CNT_W'(1);
    row_d      = ~(ROWS'(1) << s_c);
    col_d      = fb_q[s_c];
    if (blink_c && (s_c == cur_y_q)) col_d[cur_x_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sync1_q     <= '1;
      sync2_q     <= '1;
      deb_q       <= '1;
      for (int unsigned i = 0; i < NIN; i++) deb_cnt_q[i] <= '0;
      clr_prev_q  <= 1'b1;
      dir_q       <= 4'b0000;
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
      scan_cnt_q  <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      clr_row_q   <= '0;
      for (int unsigned k = 0; k < ROWS; k++)
        fb_q[k] <= ((INIT_DIAG != 0) && (k < COLS)) ? (COLS'(1) << k) : '0;
      col_q       <= (INIT_DIAG != 0) ? COLS'(1) : '0;
      row_q       <= ~ROWS'(1);
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= raw_c;
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      for (int unsigned i = 0; i < NIN; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      clr_prev_q  <= clr_prev_d;
      dir_q       <= dir_d;
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
      scan_cnt_q  <= scan_cnt_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      clr_row_q   <= clr_row_d;
      for (int unsigned k = 0; k < ROWS; k++) fb_q[k] <= fb_d[k];
      col_q       <= col_d;
      row_q       <= row_d;
      busy_q      <= busy_d;
    end
  end

  assign col   = col_q;
  assign row   = row_q;
  assign cur_x = cur_x_q;
  assign cur_y = cur_y_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_dpad_matrix_editor.sv
// Directed bench for dpad_matrix_editor: a wrapping instance and a clamping
// instance share stimulus; expected scan/cursor/pixel values come from a small model.
module tb_dpad_matrix_editor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn = 4'hF;
  logic       Abtn = 1'b1, Bbtn = 1'b1, clr_n = 1'b1;

  logic [7:0] col, row, col_c, row_c;
  logic [2:0] cur_x, cur_y, cur_x_c, cur_y_c;
  logic       busy, busy_c;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] fbm [8];
  int cx_m = 0, cy_m = 0;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else cyc <= cyc + 1;

  dpad_matrix_editor #(.ROWS(8), .COLS(8), .SCAN_SH(2), .BLINK_SH(6), .DEB_CYC(4),
    .RPT_DLY(3), .RPT_RATE(2), .WRAP(1), .INIT_DIAG(1)) dut (
    .clk(clk), .rst(rst), .btn(btn), .Abtn(Abtn), .Bbtn(Bbtn), .clr_n(clr_n),
    .col(col), .row(row), .cur_x(cur_x), .cur_y(cur_y), .busy(busy));

  dpad_matrix_editor #(.ROWS(8), .COLS(8), .SCAN_SH(2), .BLINK_SH(6), .DEB_CYC(4),
    .RPT_DLY(3), .RPT_RATE(2), .WRAP(0), .INIT_DIAG(1)) dut_c (
    .clk(clk), .rst(rst), .btn(btn), .Abtn(Abtn), .Bbtn(Bbtn), .clr_n(clr_n),
    .col(col_c), .row(row_c), .cur_x(cur_x_c), .cur_y(cur_y_c), .busy(busy_c));

  // Outputs sampled n edges after reset show counter value n-1
  function automatic int scan_of(int n);
    return (n == 0) ? 0 : n - 1;
  endfunction

  function automatic logic [7:0] exp_row(int n);
    int s;
    s = (scan_of(n) >> 2) % 8;
    return ~(8'd1 << s);
  endfunction

  function automatic logic [7:0] exp_col(int n);
    int m, s;
    logic [7:0] c;
    m = scan_of(n);
    s = (m >> 2) % 8;
    c = fbm[s];
    if ((((m >> 6) & 1) == 1) && (s == cy_m)) c[cx_m] = 1'b1;
    return c;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) fbm[k] = 8'd1 << k;
    cx_m = 0;
    cy_m = 0;
  endtask

  task automatic reset_all();
    @(negedge clk);
    rst = 1'b0; btn = 4'hF; Abtn = 1'b1; Bbtn = 1'b1; clr_n = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic edges(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_move(logic [3:0] v);
    edges(1);
    btn = v;
    edges(7);
    btn = 4'hF;
    edges(10);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (row !== 8'hFE) begin bad++; $display("FAIL reset_row got=%h want=fe", row); end
    total++; if (col !== 8'h01) begin bad++; $display("FAIL reset_col got=%h want=01", col); end
    total++; if ({cur_x, cur_y} !== 6'd0) begin bad++; $display("FAIL reset_cursor got=%0d,%0d want=0,0", cur_x, cur_y); end
    total++; if ({row_c, col_c, cur_y_c, busy_c} !== {8'hFE, 8'h01, 3'd0, 1'b0})
      begin bad++; $display("FAIL reset_clamp got=%h %h %0d %b", row_c, col_c, cur_y_c, busy_c); end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      total++; if (row !== exp_row(cyc)) begin bad++; $display("FAIL scan_row cyc=%0d got=%h want=%h", cyc, row, exp_row(cyc)); end
      total++; if (col !== exp_col(cyc)) begin bad++; $display("FAIL diag_col cyc=%0d got=%h want=%h", cyc, col, exp_col(cyc)); end
    end
  endtask

  task automatic test_move_debounce();
    int changes;
    logic [2:0] last;
    reset_all();
    edges(1);
    btn = 4'b0111;
    edges(2);
    btn = 4'hF;
    edges(12);
    total++; if (cur_x !== 3'd0) begin bad++; $display("FAIL short_press got=%0d want=0", cur_x); end
    for (int i = 0; i < 8 && (cyc % 4) != 1; i++) edges(1);
    btn = 4'b0111;
    changes = 0;
    last = cur_x;
    for (int i = 1; i <= 22; i++) begin
      edges(1);
      if (i == 10) btn = 4'hF;
      if (cur_x !== last) begin changes++; last = cur_x; end
    end
    cx_m = 1;
    total++; if (changes !== 1) begin bad++; $display("FAIL single_move got=%0d moves want=1", changes); end
    total++; if ({cur_x, cur_y} !== {3'd1, 3'd0}) begin bad++; $display("FAIL move_pos got=%0d,%0d want=1,0", cur_x, cur_y); end
  endtask

  task automatic test_wrap_clamp();
    int nchg, clamp_bad;
    int tval [3];
    int tcyc [3];
    logic [2:0] last;
    reset_all();
    edges(1);
    btn = 4'b1110;
    nchg = 0; clamp_bad = 0;
    last = cur_x;
    for (int i = 0; i < 60 && nchg < 3; i++) begin
      edges(1);
      if (cur_x !== last) begin tval[nchg] = int'(cur_x); tcyc[nchg] = cyc; nchg++; last = cur_x; end
      if (cur_x_c !== 3'd0) clamp_bad++;
    end
    btn = 4'hF;
    total++; if (nchg !== 3) begin bad++; $display("FAIL wrap_timeout got=%0d moves want=3", nchg); end
    else begin
      total++; if (tval[0] !== 7) begin bad++; $display("FAIL wrap_first got=%0d want=7", tval[0]); end
      total++; if (tval[1] !== 6 || tval[2] !== 5) begin bad++; $display("FAIL wrap_repeat got=%0d,%0d want=6,5", tval[1], tval[2]); end
      total++; if ((tcyc[1] - tcyc[0]) < 9 || (tcyc[1] - tcyc[0]) > 12)
        begin bad++; $display("FAIL rpt_delay got=%0d clks want=9..12", tcyc[1] - tcyc[0]); end
      total++; if ((tcyc[2] - tcyc[1]) !== 8) begin bad++; $display("FAIL rpt_rate got=%0d clks want=8", tcyc[2] - tcyc[1]); end
    end
    total++; if (clamp_bad !== 0) begin bad++; $display("FAIL clamp_hold got=%0d bad samples want=0", clamp_bad); end
    edges(20);
  endtask

  task automatic test_edit();
    reset_all();
    repeat (3) press_move(4'b0111);
    repeat (2) press_move(4'b1101);
    cx_m = 3; cy_m = 2;
    total++; if ({cur_x, cur_y} !== {3'd3, 3'd2}) begin bad++; $display("FAIL edit_cursor got=%0d,%0d want=3,2", cur_x, cur_y); end
    Abtn = 1'b0; Bbtn = 1'b0;
    edges(12);
    fbm[2] = 8'h04;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      total++; if (col !== exp_col(cyc)) begin bad++; $display("FAIL b_wins cyc=%0d got=%h want=%h", cyc, col, exp_col(cyc)); end
    end
    @(posedge clk); #1;
    Bbtn = 1'b1;
    edges(12);
    fbm[2] = 8'h0C;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      total++; if (col !== exp_col(cyc)) begin bad++; $display("FAIL a_sets cyc=%0d got=%h want=%h", cyc, col, exp_col(cyc)); end
    end
    @(posedge clk); #1;
    Abtn = 1'b1;
    edges(10);
  endtask

  task automatic test_two_dir();
    int changes;
    btn = 4'b0101;
    changes = 0;
    for (int i = 0; i < 14; i++) begin
      edges(1);
      if ({cur_x, cur_y} !== {3'd3, 3'd2}) changes++;
    end
    btn = 4'hF;
    edges(10);
    total++; if (changes !== 0) begin bad++; $display("FAIL two_dir got=%0d moved samples want=0", changes); end
    total++; if ({cur_x, cur_y} !== {3'd3, 3'd2}) begin bad++; $display("FAIL two_dir_pos got=%0d,%0d want=3,2", cur_x, cur_y); end
  endtask

  task automatic test_clear();
    int busy_cnt;
    edges(1);
    clr_n = 1'b0;
    busy_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      edges(1);
      if (busy === 1'b1) busy_cnt++;
      if (i == 1) begin Abtn = 1'b0; btn = 4'b0111; end
      if (i == 5) clr_n = 1'b1;
      if (i == 6) begin Abtn = 1'b1; btn = 4'hF; end
    end
    for (int k = 0; k < 8; k++) fbm[k] = 8'h00;
    total++; if (busy_cnt !== 8) begin bad++; $display("FAIL busy_len got=%0d want=8", busy_cnt); end
    total++; if ({cur_x, cur_y} !== {3'd3, 3'd2}) begin bad++; $display("FAIL move_in_clear got=%0d,%0d want=3,2", cur_x, cur_y); end
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      total++; if (col !== exp_col(cyc)) begin bad++; $display("FAIL cleared cyc=%0d got=%h want=%h", cyc, col, exp_col(cyc)); end
    end
    @(posedge clk); #1;
    clr_n = 1'b0;
    edges(5);
    clr_n = 1'b1;
    for (int i = 0; i < 20 && busy !== 1'b1; i++) edges(1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_timeout got=%b want=1", busy); end
    edges(3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if ({busy, row, col, cur_x, cur_y} !== {1'b0, 8'hFE, 8'h01, 3'd0, 3'd0})
      begin bad++; $display("FAIL abort_reset got=%b %h %h %0d,%0d want=0 fe 01 0,0", busy, row, col, cur_x, cur_y); end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      total++; if (col !== exp_col(cyc) || busy !== 1'b0)
        begin bad++; $display("FAIL diag_restore cyc=%0d got=%h busy=%b want=%h", cyc, col, busy, exp_col(cyc)); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_move_debounce();
    test_wrap_clamp();
    test_edit();
    test_two_dir();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
